// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-master (CPU, FTDI host) arbiter for a single 8-bit memory bus.
//   A requester is granted in IDLE (round-robin when both ask). Its
//   address, write strobe and write data are latched and driven on the
//   shared bus. The access then either:
//     - goes IDLE->DONE as an error (unmapped address, or CPU to SPI), or
//     - goes IDLE->ADDR->WAIT(W cycles)->DONE, where W is the region's
//       wait count. W=0 skips WAIT entirely.
//   DONE pulses the owner's ack for one cycle and returns to IDLE.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_cpu_*  / o_cpu_*      CPU request (level, held until ack) / response
//   i_host_* / o_host_*     FTDI host request / response
//   o_bus_addr/we/wdata     latched request of the current owner
//   o_bus_en                bus cycle active (ADDR and WAIT)
//   o_FT_CS                 active-low, 0 while the host owns an active cycle
//   i_bus_rdata             read data from the selected target
//   o_busy                  FSM not in IDLE
module mem_bus_arbiter #(
  parameter int unsigned SRAM_WAIT = 1,  // 0x0000-0x0FFF, 0..15
  parameter int unsigned UART_WAIT = 2,  // 0xA000-0xA002, 0..15
  parameter int unsigned SPI_WAIT  = 4   // 0xF000-0xFFFF, 0..15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // CPU
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic        o_cpu_ack,
  output logic        o_cpu_err,
  output logic [7:0]  o_cpu_rdata,
  // FTDI host
  input  logic        i_host_req,
  input  logic        i_host_we,
  input  logic [15:0] i_host_addr,
  input  logic [7:0]  i_host_wdata,
  output logic        o_host_ack,
  output logic        o_host_err,
  output logic [7:0]  o_host_rdata,
  // shared bus
  output logic [15:0] o_bus_addr,
  output logic        o_bus_we,
  output logic [7:0]  o_bus_wdata,
  output logic        o_bus_en,
  output logic        o_FT_CS,
  input  logic [7:0]  i_bus_rdata,
  output logic        o_busy
);

  localparam logic [3:0] SRAM_W = SRAM_WAIT[3:0];
  localparam logic [3:0] UART_W = UART_WAIT[3:0];
  localparam logic [3:0] SPI_W  = SPI_WAIT[3:0];

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } bus_req_t;

  state_t   r_state, w_next;
  bus_req_t r_req;             // latched request of the owner
  logic     r_last_host;       // last/current owner: 1 = host, 0 = CPU
  logic [3:0] r_wait;          // wait count of the granted region
  logic [3:0] r_cnt;           // WAIT down-counter
  logic [7:0] r_cpu_rdata, r_host_rdata;
  logic       r_cpu_err, r_host_err;

  // ---------------------------------------------------------------------
  // Requester selection and region decode of the candidate request
  // ---------------------------------------------------------------------
  logic       w_any_req;
  logic       w_pick_host;
  bus_req_t   w_sel;
  logic       w_in_sram, w_in_uart, w_in_spi;
  logic       w_sel_err;
  logic [3:0] w_sel_wait;

  always_comb begin
    w_any_req   = i_cpu_req | i_host_req;
    // Host wins when alone, or when both ask and the CPU owned last.
    w_pick_host = i_host_req & (~i_cpu_req | ~r_last_host);
    if (w_pick_host) begin
      w_sel.addr  = i_host_addr;
      w_sel.we    = i_host_we;
      w_sel.wdata = i_host_wdata;
    end else begin
      w_sel.addr  = i_cpu_addr;
      w_sel.we    = i_cpu_we;
      w_sel.wdata = i_cpu_wdata;
    end
    w_in_sram  = (w_sel.addr[15:12] == 4'h0);
    w_in_uart  = (w_sel.addr >= 16'hA000) && (w_sel.addr <= 16'hA002);
    w_in_spi   = (w_sel.addr[15:12] == 4'hF);
    // SPI belongs to the host only; the CPU hitting it is rejected.
    w_sel_err  = ~(w_in_sram | w_in_uart | w_in_spi) | (w_in_spi & ~w_pick_host);
    w_sel_wait = 4'd0;
    if (w_in_sram)      w_sel_wait = SRAM_W;
    else if (w_in_uart) w_sel_wait = UART_W;
    else if (w_in_spi)  w_sel_wait = SPI_W;
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  logic w_grant;
  logic w_enter_done;
  logic w_load_cnt;
  logic w_dec_cnt;
  logic w_bus_en;
  logic w_ack;
  logic w_done_host;   // whose response registers the DONE entry updates
  logic w_done_err;
  logic w_done_rd;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_grant      = 1'b0;
    w_enter_done = 1'b0;
    w_load_cnt   = 1'b0;
    w_dec_cnt    = 1'b0;
    w_bus_en     = 1'b0;
    w_ack        = 1'b0;
    w_done_host  = r_last_host;
    w_done_err   = 1'b0;
    w_done_rd    = ~r_req.we;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant = 1'b1;
          if (w_sel_err) begin
            // Rejected accesses never touch the bus.
            w_next       = S_DONE;
            w_enter_done = 1'b1;
            w_done_host  = w_pick_host;
            w_done_err   = 1'b1;
            w_done_rd    = 1'b0;
          end else begin
            w_next = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        w_bus_en = 1'b1;
        if (r_wait == 4'd0) begin
          w_next       = S_DONE;
          w_enter_done = 1'b1;
        end else begin
          w_next     = S_WAIT;
          w_load_cnt = 1'b1;
        end
      end
      S_WAIT: begin
        w_bus_en = 1'b1;
        if (r_cnt == 4'd1) begin
          w_next       = S_DONE;
          w_enter_done = 1'b1;
        end else begin
          w_dec_cnt = 1'b1;
        end
      end
      S_DONE: begin
        w_ack  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: latched request, owner, wait counter
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_req       <= '0;
      r_last_host <= 1'b0;
      r_wait      <= 4'd0;
      r_cnt       <= 4'd0;
    end else begin
      if (w_grant) begin
        r_req       <= w_sel;
        r_last_host <= w_pick_host;
        r_wait      <= w_sel_wait;
      end else if (r_state == S_DONE) begin
        // Bus lines drop back to 0 once the transaction is over.
        r_req <= '0;
      end
      if (w_load_cnt)     r_cnt <= r_wait;
      else if (w_dec_cnt) r_cnt <= r_cnt - 4'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Per-requester response registers; only the owner's are touched.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cpu_rdata  <= 8'h00;
      r_host_rdata <= 8'h00;
      r_cpu_err    <= 1'b0;
      r_host_err   <= 1'b0;
    end else if (w_enter_done) begin
      if (w_done_host) begin
        r_host_err <= w_done_err;
        if (w_done_err)     r_host_rdata <= 8'h00;
        else if (w_done_rd) r_host_rdata <= i_bus_rdata;
      end else begin
        r_cpu_err <= w_done_err;
        if (w_done_err)     r_cpu_rdata <= 8'h00;
        else if (w_done_rd) r_cpu_rdata <= i_bus_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign o_cpu_ack    = w_ack & ~r_last_host;
  assign o_host_ack   = w_ack &  r_last_host;
  assign o_cpu_err    = r_cpu_err;
  assign o_host_err   = r_host_err;
  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_host_rdata = r_host_rdata;
  assign o_bus_addr   = r_req.addr;
  assign o_bus_we     = r_req.we;
  assign o_bus_wdata  = r_req.wdata;
  assign o_bus_en     = w_bus_en;
  assign o_FT_CS      = ~(w_bus_en & r_last_host);
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL use one clock, i_clk, and a synchronous, active-high reset, i_reset.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
- SRAM_WAIT, 1, wait cycles for 0x0000-0x0FFF
- UART_WAIT, 2, wait cycles for 0xA000-0xA002
- SPI_WAIT, 4, wait cycles for 0xF000-0xFFFF
- Each parameter SHALL lie in the range 0..15.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- i_clk  in  1  clock
- i_reset  in  1  synchronous reset, active-high
- i_cpu_req  in  1  CPU request, level, held until ack
- i_cpu_we  in  1  CPU write=1 / read=0
- i_cpu_addr  in  16  CPU address
- i_cpu_wdata  in  8  CPU write data
- o_cpu_ack  out  1  one-cycle completion pulse
- o_cpu_err  out  1  valid with o_cpu_ack; access rejected
- o_cpu_rdata  out  8  read data, valid with o_cpu_ack
- i_host_req, i_host_we, i_host_addr[16], i_host_wdata[8], o_host_ack, o_host_err, o_host_rdata[8]: same meanings as the CPU signals, for the FTDI host
- o_bus_addr  out  16  shared address to address_decoder
- o_bus_we  out  1  shared write strobe
- o_bus_wdata  out  8  shared write data
- o_bus_en  out  1  bus cycle active
- o_FT_CS  out  1  active-low; 0 only while the host owns an active bus cycle
- i_bus_rdata  in  8  read data returned from the selected target
- o_busy  out  1  state is not IDLE

Function
REQ-004 The FSM SHALL have the states IDLE, ADDR, WAIT and DONE.
REQ-005 In IDLE, with exactly one requester asserted, that requester SHALL be granted.
REQ-006 With both requesters asserted in IDLE, grant SHALL go to the requester that was not the last owner (round-robin).
REQ-007 The last-owner register SHALL update on every grant.
REQ-008 On grant, the owner's addr, we and wdata SHALL be latched and driven on o_bus_addr, o_bus_we and o_bus_wdata until the state returns to IDLE.
REQ-009 Region decode SHALL be: SRAM 0x0000-0x0FFF; UART 0xA000-0xA002; SPI 0xF000-0xFFFF; all other addresses unmapped.
REQ-010 Any access to an unmapped address, and any CPU access to the SPI region, SHALL be an error access.
REQ-011 An error access SHALL go IDLE->DONE, never assert o_bus_en, and assert ack with err=1, rdata=0.
REQ-012 A valid access SHALL go IDLE->ADDR; ADDR SHALL last 1 cycle with o_bus_en=1.
REQ-013 From ADDR, the FSM SHALL enter WAIT with the counter loaded to W (the region's wait parameter), or go directly to DONE if W=0.
REQ-014 WAIT SHALL hold o_bus_en=1, decrement the counter each cycle, and exit to DONE when the counter reaches 1.
REQ-015 i_bus_rdata SHALL be captured into the owner's rdata register on the clock edge entering DONE, for reads only.
REQ-016 Writes SHALL leave rdata at its previous value.
REQ-017 DONE SHALL last 1 cycle, pulse the owner's ack (err=0 for a valid access), and then go to IDLE unconditionally.
REQ-018 Latency from the edge sampling req in IDLE to ack high SHALL be W+2 cycles for a valid access and 1 cycle for an error access.
REQ-019 o_FT_CS SHALL equal ~(o_bus_en & host_is_owner).
REQ-020 A request deasserted mid-transaction SHALL be ignored; the transaction SHALL complete and ack SHALL still pulse.
REQ-021 A req still high in the IDLE following DONE SHALL be treated as a new transaction.
REQ-022 The non-owner's ack, err and rdata SHALL remain unchanged during another requester's transaction.

Reset
REQ-023 While i_reset=1 on a clock edge, the block SHALL set: state IDLE; last owner=CPU; all acks, errs, rdata, o_bus_* and o_busy to 0; o_FT_CS to 1.
REQ-024 A reset during ADDR, WAIT or DONE SHALL abort the transaction with no ack issued.

Verification
REQ-025 CPU read 0x0010, SRAM_WAIT=1, i_bus_rdata=0x5A -> o_bus_en high for 2 cycles, o_FT_CS=1, o_cpu_ack 3 cycles after sampling, o_cpu_rdata=0x5A.
REQ-026 Host write 0xF000, data 0xC3 -> o_FT_CS=0 for 5 cycles (ADDR + 4 WAIT), o_bus_wdata=0xC3, o_host_ack 6 cycles after sampling, err=0.
REQ-027 CPU read 0xF800 -> no o_bus_en, o_cpu_ack after 1 cycle, o_cpu_err=1, o_cpu_rdata=0x00.
REQ-028 Both requesters assert simultaneously after reset -> host served first, then CPU, then host again while both stay asserted.
REQ-029 Host read 0x1234 -> err ack after 1 cycle; CPU read 0xA001 pending at the same time -> served after the host's error transaction completes.
REQ-030 Assert i_reset during a WAIT cycle -> next cycle IDLE, o_bus_en=0, o_FT_CS=1, no ack ever issued for the aborted access.
